// File: rtl/aurora_rx_deframer.sv
// Aurora RX deframer: rebuilds router packets from SOF/EOF-framed 64-bit words,
// repairs malformed frames and buffers output words in a FIFO with an almost-full flag.
module aurora_rx_deframer #(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned AW           = 6,
  parameter int unsigned AFULL_THRESH = 48
) (
  input  logic        CLK,
  input  logic        SYS_RST,
  input  logic [63:0] RX_DATA,
  input  logic        RX_VALID,
  input  logic        RX_SOF,
  input  logic        RX_EOF,
  output logic [63:0] Q,
  output logic        Q_VALID,
  input  logic        Q_BP,
  output logic        AFULL,
  output logic        OVF,
  output logic [15:0] ERR_CNT
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_THRESH);

  typedef enum logic [2:0] {
    S_HUNT,
    S_HEAD,
    S_PAYLOAD,
    S_DRAIN,
    S_PAD
  } state_t;

  state_t      state, state_nxt;
  logic [55:0] togo, togo_nxt;
  logic        push, fsm_err, frame_word;
  logic [63:0] push_data;

  logic [63:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop, wr_ok, drop;

  logic        is_len;
  logic [55:0] len;

  assign is_len = (RX_DATA[63:56] == 8'h00);
  assign len    = RX_DATA[55:0];

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign pop   = !empty && !Q_BP;
  // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
  assign wr_ok = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_comb begin
    state_nxt  = state;
    togo_nxt   = togo;
    push       = 1'b0;
    push_data  = RX_DATA;
    fsm_err    = 1'b0;
    frame_word = 1'b0;
    case (state)
      S_HUNT: begin
        if (RX_VALID) begin
          if (RX_SOF) frame_word = 1'b1;
          else        fsm_err    = 1'b1;
        end
      end
      S_HEAD: begin
        if (RX_VALID) begin
          if (RX_SOF) begin
            fsm_err   = 1'b1;
            togo_nxt  = 56'd1;
            state_nxt = S_PAD;
          end else begin
            frame_word = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (RX_VALID) begin
          if (RX_SOF) begin
            fsm_err   = 1'b1;
            state_nxt = S_PAD;
          end else begin
            push = 1'b1;
            if (togo <= 56'd1) begin
              if (RX_EOF) begin
                state_nxt = S_HUNT;
              end else begin
                fsm_err   = 1'b1;
                state_nxt = S_DRAIN;
              end
            end else begin
              togo_nxt = togo - 56'd1;
              if (RX_EOF) begin
                fsm_err   = 1'b1;
                state_nxt = S_PAD;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (RX_VALID && RX_EOF) state_nxt = S_HUNT;
      end
      S_PAD: begin
        fsm_err = RX_VALID;
        if (!full) begin
          push      = 1'b1;
          push_data = '0;
          if (togo != '0)    togo_nxt  = togo - 56'd1;
          if (togo <= 56'd1) state_nxt = S_HUNT;
        end
      end
      default: state_nxt = S_HUNT;
    endcase

    // Header/length classification shared by a SOF word in HUNT and any word in HEAD.
    if (frame_word) begin
      push = 1'b1;
      if (!is_len) begin
        if (RX_EOF) begin
          fsm_err   = 1'b1;
          togo_nxt  = 56'd1;
          state_nxt = S_PAD;
        end else begin
          state_nxt = S_HEAD;
        end
      end else if (len == '0) begin
        if (RX_EOF) begin
          state_nxt = S_HUNT;
        end else begin
          fsm_err   = 1'b1;
          state_nxt = S_DRAIN;
        end
      end else begin
        togo_nxt = len;
        if (RX_EOF) begin
          fsm_err   = 1'b1;
          state_nxt = S_PAD;
        end else begin
          state_nxt = S_PAYLOAD;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state   <= S_HUNT;
      togo    <= '0;
      OVF     <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      state <= state_nxt;
      togo  <= togo_nxt;
      if (drop) OVF <= 1'b1;
      if ((fsm_err || drop) && (ERR_CNT != '1)) ERR_CNT <= ERR_CNT + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      Q       <= '0;
      Q_VALID <= 1'b0;
      AFULL   <= 1'b0;
    end else begin
      Q_VALID <= pop;
      if (pop) begin
        Q      <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      AFULL <= (count >= AFULL_C);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_aurora_rx_deframer.sv
// Directed bench for aurora_rx_deframer: framed stimulus with hand-written expected
// output sequences, error counts and flag values.
module tb_aurora_rx_deframer;

  logic        CLK = 1'b0;
  logic        SYS_RST;
  logic [63:0] RX_DATA;
  logic        RX_VALID, RX_SOF, RX_EOF;
  logic [63:0] Q;
  logic        Q_VALID, Q_BP, AFULL, OVF;
  logic [15:0] ERR_CNT;

  aurora_rx_deframer #(.DEPTH(64), .AW(6), .AFULL_THRESH(48)) dut (
    .CLK(CLK), .SYS_RST(SYS_RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_SOF(RX_SOF), .RX_EOF(RX_EOF), .Q(Q), .Q_VALID(Q_VALID), .Q_BP(Q_BP),
    .AFULL(AFULL), .OVF(OVF), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int first_cyc = -1;
  int t0;
  logic [63:0] got[$];
  logic [63:0] exp_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    #1;
    if (Q_VALID) begin
      if (first_cyc < 0) first_cyc = cyc;
      got.push_back(Q);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] lw(input int unsigned n);
    return {8'h00, 56'(n)};
  endfunction

  function automatic logic [63:0] pw(input int unsigned n);
    return 64'hD0D0_0000_0000_0000 | 64'(n);
  endfunction

  task automatic send(input logic [63:0] d, input logic sof, input logic eof);
    @(negedge CLK);
    RX_DATA = d; RX_VALID = 1'b1; RX_SOF = sof; RX_EOF = eof;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_VALID = 1'b0; RX_SOF = 1'b0; RX_EOF = 1'b0; RX_DATA = '0;
    end
  endtask

  task automatic check_got(input string tag);
    int n;
    check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
  endtask

  initial begin
    SYS_RST = 1'b1; RX_DATA = '0; RX_VALID = 1'b0; RX_SOF = 1'b0; RX_EOF = 1'b0; Q_BP = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_q", Q, 64'h0);
    check("rst_qvalid", 64'(Q_VALID), 64'h0);
    check("rst_afull", 64'(AFULL), 64'h0);
    check("rst_ovf", 64'(OVF), 64'h0);
    check("rst_err", 64'(ERR_CNT), 64'h0);
    SYS_RST = 1'b0;
    idle(2);

    // 1: clean frame, two-cycle latency
    send(64'h0100_0000_0000_0011, 1'b1, 1'b0);
    t0 = cyc;
    send(lw(3), 1'b0, 1'b0);
    send(pw(1), 1'b0, 1'b0);
    send(pw(2), 1'b0, 1'b0);
    send(pw(3), 1'b0, 1'b1);
    idle(6);
    exp_q = '{64'h0100_0000_0000_0011, lw(3), pw(1), pw(2), pw(3)};
    check_got("t1");
    check("t1_latency", 64'(first_cyc - t0), 64'd2);
    check("t1_err", 64'(ERR_CNT), 64'd0);

    // 2: early EOF padded with zeros, then a clean frame
    got.delete();
    send(64'h0200_0000_0000_0022, 1'b1, 1'b0);
    send(lw(4), 1'b0, 1'b0);
    send(pw(21), 1'b0, 1'b0);
    send(pw(22), 1'b0, 1'b1);
    idle(6);
    send(64'h0300_0000_0000_0033, 1'b1, 1'b0);
    send(lw(1), 1'b0, 1'b0);
    send(pw(31), 1'b0, 1'b1);
    idle(6);
    exp_q = '{64'h0200_0000_0000_0022, lw(4), pw(21), pw(22), 64'h0, 64'h0,
              64'h0300_0000_0000_0033, lw(1), pw(31)};
    check_got("t2");
    check("t2_err", 64'(ERR_CNT), 64'd1);

    // 3: missing EOF -> extra words drained until EOF
    got.delete();
    send(64'h0400_0000_0000_0044, 1'b1, 1'b0);
    send(lw(2), 1'b0, 1'b0);
    send(pw(41), 1'b0, 1'b0);
    send(pw(42), 1'b0, 1'b0);
    send(pw(43), 1'b0, 1'b0);
    send(pw(44), 1'b0, 1'b0);
    send(pw(45), 1'b0, 1'b1);
    idle(3);
    send(64'h0500_0000_0000_0055, 1'b1, 1'b0);
    send(lw(0), 1'b0, 1'b1);
    idle(6);
    exp_q = '{64'h0400_0000_0000_0044, lw(2), pw(41), pw(42), 64'h0500_0000_0000_0055, lw(0)};
    check_got("t3");
    check("t3_err", 64'(ERR_CNT), 64'd2);

    // 4: backpressure, almost-full threshold, overflow drops, drain
    got.delete();
    @(negedge CLK); Q_BP = 1'b1;
    send(64'h0600_0000_0000_0066, 1'b1, 1'b0);
    send(lw(68), 1'b0, 1'b0);
    for (int i = 1; i <= 45; i++) send(pw(i), 1'b0, 1'b0);
    idle(2);
    check("t4_afull_47", 64'(AFULL), 64'd0);
    send(pw(46), 1'b0, 1'b0);
    idle(2);
    check("t4_afull_48", 64'(AFULL), 64'd1);
    for (int i = 47; i <= 68; i++) send(pw(i), 1'b0, (i == 68));
    idle(2);
    check("t4_ovf", 64'(OVF), 64'd1);
    check("t4_err", 64'(ERR_CNT), 64'd8);
    check("t4_afull_full", 64'(AFULL), 64'd1);
    check("t4_no_pop_under_bp", 64'(got.size()), 64'd0);
    @(negedge CLK); Q_BP = 1'b0;
    idle(70);
    check("t4_drain_count", 64'(got.size()), 64'd64);
    if (got.size() == 64) begin
      check("t4_first", got[0], 64'h0600_0000_0000_0066);
      check("t4_len", got[1], lw(68));
      check("t4_p1", got[2], pw(1));
      check("t4_last", got[63], pw(62));
    end
    check("t4_afull_after", 64'(AFULL), 64'd0);
    check("t4_qvalid_after", 64'(Q_VALID), 64'd0);

    // 5: stray words in HUNT, SOF mid-payload truncates and pads old frame
    got.delete();
    send(64'hAAAA_0000_0000_0001, 1'b0, 1'b0);
    send(64'hAAAA_0000_0000_0002, 1'b0, 1'b1);
    send(64'h0700_0000_0000_0077, 1'b1, 1'b0);
    send(lw(3), 1'b0, 1'b0);
    send(pw(71), 1'b0, 1'b0);
    send(64'h0800_0000_0000_0088, 1'b1, 1'b0);
    idle(8);
    exp_q = '{64'h0700_0000_0000_0077, lw(3), pw(71), 64'h0, 64'h0};
    check_got("t5");
    check("t5_err", 64'(ERR_CNT), 64'd11);
    check("t5_ovf_sticky", 64'(OVF), 64'd1);

    // 6: reset mid-payload and mid-pad
    send(64'h0900_0000_0000_0099, 1'b1, 1'b0);
    send(lw(5), 1'b0, 1'b0);
    send(pw(91), 1'b0, 1'b0);
    idle(3);
    check("t6_q_pre", Q, pw(91));
    SYS_RST = 1'b1;
    #1;
    check("t6a_q", Q, 64'h0);
    check("t6a_ovf", 64'(OVF), 64'h0);
    check("t6a_err", 64'(ERR_CNT), 64'h0);
    @(negedge CLK); SYS_RST = 1'b0;
    send(64'h0A00_0000_0000_00AA, 1'b1, 1'b0);
    send(lw(40), 1'b0, 1'b0);
    send(pw(101), 1'b0, 1'b1);
    idle(3);
    check("t6_err_pre", 64'(ERR_CNT), 64'd1);
    check("t6_qvalid_pre", 64'(Q_VALID), 64'd1);
    SYS_RST = 1'b1;
    #1;
    check("t6b_qvalid", 64'(Q_VALID), 64'h0);
    check("t6b_afull", 64'(AFULL), 64'h0);
    check("t6b_err", 64'(ERR_CNT), 64'h0);
    @(negedge CLK); SYS_RST = 1'b0;
    got.delete();
    idle(4);
    check("t6_fifo_empty", 64'(got.size()), 64'd0);
    send(64'h0B00_0000_0000_00BB, 1'b1, 1'b0);
    send(lw(1), 1'b0, 1'b0);
    send(pw(111), 1'b0, 1'b1);
    idle(6);
    exp_q = '{64'h0B00_0000_0000_00BB, lw(1), pw(111)};
    check_got("t6");
    check("t6_err", 64'(ERR_CNT), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
